// File: rtl/vend_pkg.sv
// ============================================================================
// Module      : vend_pkg
// Description : Shared types and constants for the parametrised vending FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_VEND    = 3'd2,
    ST_CHANGE  = 3'd3,
    ST_REFUND  = 3'd4
  } vend_state_t;

  localparam int UNIT_FIVE      = 1;
  localparam int UNIT_TEN       = 2;
  localparam int MAX_COIN_UNITS = UNIT_FIVE + UNIT_TEN;

  // Worst-case credit is one unit short of the price plus a five+ten pair.
  function automatic bit credit_width_ok(input int credit_w, input int max_price);
    return (max_price + MAX_COIN_UNITS - 1) < (1 << credit_w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vend_price_lut.sv
// ============================================================================
// Module      : vend_price_lut
// Description : One-hot item decode with validity flag, and index-to-price table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vend_price_lut #(
  parameter int NUM_ITEMS = 4,
  parameter int CREDIT_W  = 4,
  parameter int IDX_W     = 2,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {4'd6, 4'd5, 4'd4, 4'd3}
) (
  input  logic [NUM_ITEMS-1:0] item_sel,
  input  logic [IDX_W-1:0]     price_idx,
  output logic [IDX_W-1:0]     sel_idx,
  output logic                 sel_valid,
  output logic [CREDIT_W-1:0]  price
);

  logic w_seen;
  logic w_multi;

  always_comb begin
    w_seen  = 1'b0;
    w_multi = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (item_sel[i]) begin
        if (w_seen) w_multi = 1'b1;
        w_seen  = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
    sel_valid = w_seen & ~w_multi;
  end

  always_comb begin
    price = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (price_idx == IDX_W'(i)) price = PRICES[i*CREDIT_W +: CREDIT_W];
    end
  end

endmodule

`default_nettype wire

// File: rtl/vending_machine_param.sv
// ============================================================================
// Module      : vending_machine_param
// Description : Multi-item vending FSM with shared credit, change, refund and
//               coin rejection. Optional COLLECT inactivity timeout when the
//               macro VEND_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vending_machine_param
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS      = 4,
  parameter int CREDIT_W       = 4,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {4'd6, 4'd5, 4'd4, 4'd3},
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IDX_W         = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_ITEMS-1:0] item_sel,
  input  logic                 five_in,
  input  logic                 ten_in,
  input  logic                 cancel,
  output logic                 dispense,
  output logic [IDX_W-1:0]     dispense_idx,
  output logic                 five_out,
  output logic                 coin_reject,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 busy
);

  function automatic int max_price();
    int m;
    m = 0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (int'(PRICES[i*CREDIT_W +: CREDIT_W]) > m) m = int'(PRICES[i*CREDIT_W +: CREDIT_W]);
    end
    return m;
  endfunction

  localparam int c_max_price = max_price();

  if (!credit_width_ok(CREDIT_W, c_max_price)) begin : g_width_check
    $error("CREDIT_W too narrow for max(PRICES)+2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  vend_state_t         r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [IDX_W-1:0]    r_item_idx;
  logic                r_coin_reject;

  logic [IDX_W-1:0]    w_sel_idx;
  logic                w_sel_valid;
  logic [IDX_W-1:0]    w_price_idx;
  logic [CREDIT_W-1:0] w_price;
  logic [CREDIT_W-1:0] w_coin_units;
  logic [CREDIT_W-1:0] w_sum;
  logic                w_coin;
  logic                w_timeout;

  assign w_coin       = five_in | ten_in;
  assign w_coin_units = (five_in ? CREDIT_W'(UNIT_FIVE) : '0) + (ten_in ? CREDIT_W'(UNIT_TEN) : '0);
  // Credit is zero in IDLE, so one adder serves both the first coin and later ones.
  assign w_sum        = r_credit + w_coin_units;
  assign w_price_idx  = (r_state == ST_IDLE) ? w_sel_idx : r_item_idx;

  vend_price_lut #(
    .NUM_ITEMS (NUM_ITEMS),
    .CREDIT_W  (CREDIT_W),
    .IDX_W     (IDX_W),
    .PRICES    (PRICES)
  ) u_price_lut (
    .item_sel  (item_sel),
    .price_idx (w_price_idx),
    .sel_idx   (w_sel_idx),
    .sel_valid (w_sel_valid),
    .price     (w_price)
  );

`ifdef VEND_TIMEOUT_EN
  localparam int c_tmo_w = $clog2(TIMEOUT_CYCLES);
  logic [c_tmo_w-1:0] r_idle_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                r_idle_cnt <= '0;
    else if (r_state != ST_COLLECT || w_coin) r_idle_cnt <= '0;
    else                                      r_idle_cnt <= r_idle_cnt + 1'b1;
  end

  assign w_timeout = (r_state == ST_COLLECT) && !w_coin &&
                     (r_idle_cnt == c_tmo_w'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_credit      <= '0;
      r_item_idx    <= '0;
      r_coin_reject <= 1'b0;
    end else begin
      r_coin_reject <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_coin) begin
            if (w_sel_valid) begin
              r_item_idx <= w_sel_idx;
              if (w_sum >= w_price) begin
                r_state  <= ST_VEND;
                r_credit <= w_sum - w_price;
              end else begin
                r_state  <= ST_COLLECT;
                r_credit <= w_sum;
              end
            end else begin
              r_coin_reject <= 1'b1;
            end
          end
        end
        ST_COLLECT: begin
          // A completing purchase takes priority over cancel or timeout.
          if (w_sum >= w_price) begin
            r_state  <= ST_VEND;
            r_credit <= w_sum - w_price;
          end else begin
            r_credit <= w_sum;
            if (cancel || w_timeout) r_state <= ST_REFUND;
          end
        end
        ST_VEND: begin
          r_coin_reject <= w_coin;
          r_state       <= (r_credit != '0) ? ST_CHANGE : ST_IDLE;
        end
        ST_CHANGE, ST_REFUND: begin
          r_coin_reject <= w_coin;
          r_credit      <= r_credit - 1'b1;
          if (r_credit == CREDIT_W'(1)) r_state <= ST_IDLE;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_credit <= '0;
        end
      endcase
    end
  end

  assign dispense     = (r_state == ST_VEND);
  assign dispense_idx = r_item_idx;
  assign five_out     = (r_state == ST_CHANGE) || (r_state == ST_REFUND);
  assign coin_reject  = r_coin_reject;
  assign credit       = r_credit;
  assign busy         = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/vending_machine_param.md
Name: vending_machine_param

Overview:
- Parametrised successor to the per-item vending FSMs: one shared credit accumulator serves NUM_ITEMS products, each priced from a parameter table.
- Adds features the fixed designs lack:
  - multi-unit change returned as a pulse train
  - cancel/refund
  - coin rejection outside the collect phase
  - simultaneous-coin acceptance
- Sits between the coin-mechanism front end and the dispenser actuator.

Parameters:
- NUM_ITEMS, 4: number of selectable items; item_sel width.
- CREDIT_W, 4: credit register width in units of 5.
- PRICES, {4'd6,4'd5,4'd4,4'd3}: packed NUM_ITEMS*CREDIT_W prices in units of 5; item i uses slice i, giving defaults 15/20/25/30.
- TIMEOUT_CYCLES, 1024: inactivity limit. Used only with VEND_TIMEOUT_EN.

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high reset.
- item_sel, input, NUM_ITEMS: one-hot item selection. Any other pattern is invalid.
- five_in, input, 1: 5-unit coin, one-cycle pulse.
- ten_in, input, 1: 10-unit coin, one-cycle pulse.
- cancel, input, 1: customer abort, one-cycle pulse.
- dispense, output, 1: one-cycle pulse, vend the latched item.
- dispense_idx, output, $clog2(NUM_ITEMS): index of the item being vended. Valid while dispense=1.
- five_out, output, 1: one pulse per 5-unit returned.
- coin_reject, output, 1: one-cycle pulse; the coin sampled the previous cycle was not accepted.
- credit, output, CREDIT_W: current credit, or remaining change/refund.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- Reset: asynchronous, active-high.
  - State=IDLE; credit=0; latched item index=0.
  - dispense, five_out, coin_reject, busy all 0.
  - Asserting reset mid-operation discards credit silently; no refund pulses.
- Coin value per cycle: coin_units = five_in*1 + ten_in*2. Both high in the same cycle adds 3 units; both coins are accepted.
- States: IDLE, COLLECT, VEND, CHANGE, REFUND. All outputs are registered or state-decoded (Moore).
  - dispense = (state==VEND).
  - five_out = (state==CHANGE || state==REFUND).
- IDLE:
  - Coin with a valid one-hot item_sel: latch the index, credit=coin_units, go to COLLECT.
  - If coin_units ≥ price, go straight to VEND with credit=coin_units−price.
  - Coin with an invalid item_sel: coin_reject=1 the next cycle; stay in IDLE.
  - cancel is ignored.
- COLLECT:
  - item_sel is ignored; the item is latched at first coin.
  - Let sum = credit + coin_units. If sum ≥ price: go to VEND, credit = sum − price (change owed). Otherwise credit = sum.
  - cancel with no purchase completing this cycle: go to REFUND, credit = sum. A coin arriving with cancel is accepted and then refunded.
  - If cancel and price-reached occur in the same cycle, the vend wins and cancel is dropped.
- VEND: exactly one cycle. Next state is CHANGE if credit>0, else IDLE.
- CHANGE and REFUND:
  - Each cycle: five_out=1, credit decrements by 1.
  - On the cycle credit reaches 0, transition to IDLE. The five_out pulse count equals the credit value on entry.
- Coins sampled in VEND, CHANGE or REFUND are not credited; coin_reject=1 on the following cycle. A five+ten pair gives a single reject pulse.
- Latency:
  - A completing coin sampled at edge t gives dispense high in cycle t+1.
  - The first change pulse comes in cycle t+2.
- Width rule: CREDIT_W must hold max(PRICES)+2. An elaboration-time check fails otherwise. No saturation logic is required.

Optional Feature:
- Macro: VEND_TIMEOUT_EN.
- When defined:
  - A counter runs in COLLECT and clears on any accepted coin.
  - When it reaches TIMEOUT_CYCLES−1 with no coin, the FSM goes to REFUND exactly as if cancel had been asserted.
  - The counter clears on entering COLLECT and on reset.
- When undefined: no counter logic; COLLECT waits indefinitely.

Decomposition:
- Package vend_pkg holds:
  - the state enum typedef (vend_state_t)
  - coin unit constants (UNIT_FIVE=1, UNIT_TEN=2)
  - a function returning the slice width check.
- Sub-module vend_price_lut:
  - one-hot item_sel → index, plus a valid flag (exactly one bit set)
  - index → price slice from PRICES
  - purely combinational, instantiated once.

Test Plan:
- Reset, item_sel=0001 (price 3), five_in ×3 on consecutive cycles → dispense pulse 1 cycle after the third coin, dispense_idx=0, no five_out.
- item_sel=0001, ten_in then ten_in → credit 2, then sum 4. VEND with credit=1, then exactly one five_out pulse, then IDLE.
- item_sel=1000 (price 6), five_in+ten_in same cycle, then cancel → credit=3, REFUND gives exactly 3 consecutive five_out pulses, busy falls after the last one.
- item_sel=0011 (invalid) with five_in → coin_reject the next cycle, state stays IDLE, credit=0; also ten_in during CHANGE → coin_reject, change count unchanged.
- item_sel=0100 (price 5), four five_in pulses, assert reset during COLLECT → all outputs 0 immediately (asynchronous), credit=0, no refund pulses after release.
- With VEND_TIMEOUT_EN and TIMEOUT_CYCLES=16: one five_in, then idle 16 cycles → REFUND with one five_out. Without the macro, same stimulus → stays in COLLECT with credit=1.
